// File: rtl/vu_meter_ctrl.sv
// Frame sequencer and sync scheduler for vu_meter: accepts parallel multichannel
// frames, serialises enabled channels one per clock, and paces the vm_sync pulse.
module vu_meter_ctrl #(
    parameter int unsigned NR_CHANNELS   = 4,
    parameter int unsigned INPUT_WIDTH   = 24,
    parameter int unsigned SYNC_DIVIDER  = 1024,
    localparam int unsigned CHANNEL_WIDTH = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NR_CHANNELS*INPUT_WIDTH-1:0] s_frame_d,
    input  logic                               s_frame_dv,
    output logic                               s_frame_rdy,
    input  logic [NR_CHANNELS-1:0]             ch_enable,
    input  logic                               sync_enable,
    output logic [INPUT_WIDTH-1:0]             vm_signal_d,
    output logic [CHANNEL_WIDTH-1:0]           vm_signal_ch,
    output logic                               vm_signal_dv,
    output logic                               vm_sync
);

    localparam int unsigned DIV_WIDTH = $clog2(SYNC_DIVIDER);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SYNC_DIVIDER - 1);

    typedef enum logic [0:0] {
        IDLE,
        SCAN
    } state_t;

    state_t                           state;
    logic [NR_CHANNELS-1:0]           pending;
    logic [NR_CHANNELS*INPUT_WIDTH-1:0] frame_q;
    logic [DIV_WIDTH-1:0]             div_cnt;

    logic [NR_CHANNELS-1:0]           src_mask;
    logic [NR_CHANNELS*INPUT_WIDTH-1:0] src_frame;
    logic [NR_CHANNELS-1:0]           rest_mask;
    logic                             sel_found;
    logic [CHANNEL_WIDTH-1:0]         sel_idx;
    logic [INPUT_WIDTH-1:0]           sel_data;

    // In IDLE the first channel is picked straight from the inputs so it can be
    // emitted in the cycle right after capture.
    always_comb begin
        src_mask  = (state == IDLE) ? ch_enable : pending;
        src_frame = (state == IDLE) ? s_frame_d : frame_q;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_data  = '0;
        rest_mask = src_mask;
        for (int unsigned i = 0; i < NR_CHANNELS; i++) begin
            if (!sel_found && src_mask[i]) begin
                sel_found    = 1'b1;
                sel_idx      = CHANNEL_WIDTH'(i);
                sel_data     = src_frame[i*INPUT_WIDTH +: INPUT_WIDTH];
                rest_mask[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pending      <= '0;
            frame_q      <= '0;
            s_frame_rdy  <= 1'b0;
            vm_signal_d  <= '0;
            vm_signal_ch <= '0;
            vm_signal_dv <= 1'b0;
        end else begin
            vm_signal_dv <= 1'b0;
            case (state)
                IDLE: begin
                    s_frame_rdy <= 1'b1;
                    // An all-zero mask drops the frame without leaving IDLE.
                    if (s_frame_dv && s_frame_rdy && sel_found) begin
                        frame_q      <= s_frame_d;
                        pending      <= rest_mask;
                        vm_signal_d  <= sel_data;
                        vm_signal_ch <= sel_idx;
                        vm_signal_dv <= 1'b1;
                        s_frame_rdy  <= 1'b0;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    if (sel_found) begin
                        pending      <= rest_mask;
                        vm_signal_d  <= sel_data;
                        vm_signal_ch <= sel_idx;
                        vm_signal_dv <= 1'b1;
                    end else begin
                        s_frame_rdy <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            vm_sync <= 1'b0;
        end else if (!sync_enable) begin
            div_cnt <= '0;
            vm_sync <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            vm_sync <= (div_cnt == DIV_LAST);
        end
    end

endmodule

// File: tb/tb_vu_meter_ctrl.sv
// Directed bench for vu_meter_ctrl: vector table for frame scans plus sequences
// for drop/accept, sync pacing, back-to-back frames and mid-scan reset.
module tb_vu_meter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] s_frame_d;
    logic        s_frame_dv;
    logic        s_frame_rdy;
    logic [3:0]  ch_enable;
    logic        sync_enable;
    logic [23:0] vm_signal_d;
    logic [1:0]  vm_signal_ch;
    logic        vm_signal_dv;
    logic        vm_sync;

    int checks = 0;
    int errors = 0;
    int rel;

    vu_meter_ctrl #(
        .NR_CHANNELS (4),
        .INPUT_WIDTH (24),
        .SYNC_DIVIDER(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_frame_d   (s_frame_d),
        .s_frame_dv  (s_frame_dv),
        .s_frame_rdy (s_frame_rdy),
        .ch_enable   (ch_enable),
        .sync_enable (sync_enable),
        .vm_signal_d (vm_signal_d),
        .vm_signal_ch(vm_signal_ch),
        .vm_signal_dv(vm_signal_dv),
        .vm_sync     (vm_sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        mask;
        logic [95:0]       frame;
        int                n;
        logic [3:0][1:0]   ch;
        logic [3:0][23:0]  d;
    } vec_t;

    vec_t vecs[6];
    logic [95:0] bb[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{4'hF, {24'h000001, 24'h7FFFFF, 24'hF00000, 24'h100000}, 4,
                    {2'd3, 2'd2, 2'd1, 2'd0},
                    {24'h000001, 24'h7FFFFF, 24'hF00000, 24'h100000}};
        vecs[1] = '{4'hA, {24'h444444, 24'h333333, 24'h222222, 24'h111111}, 2,
                    {2'd0, 2'd0, 2'd3, 2'd1},
                    {24'h0, 24'h0, 24'h444444, 24'h222222}};
        vecs[2] = '{4'h0, {24'h555555, 24'h666666, 24'h777777, 24'h888888}, 0,
                    {2'd0, 2'd0, 2'd0, 2'd0},
                    {24'h0, 24'h0, 24'h0, 24'h0}};
        vecs[3] = '{4'h4, {24'h800000, 24'h0000FF, 24'h123456, 24'hFFFFFF}, 1,
                    {2'd0, 2'd0, 2'd0, 2'd2},
                    {24'h0, 24'h0, 24'h0, 24'h0000FF}};
        vecs[4] = '{4'h9, {24'h800000, 24'h0000FF, 24'h123456, 24'hFFFFFF}, 2,
                    {2'd0, 2'd0, 2'd3, 2'd0},
                    {24'h0, 24'h0, 24'h800000, 24'hFFFFFF}};
        vecs[5] = '{4'h8, {24'h7FFFFF, 24'h000000, 24'h000000, 24'h000000}, 1,
                    {2'd0, 2'd0, 2'd0, 2'd3},
                    {24'h0, 24'h0, 24'h0, 24'h7FFFFF}};
        bb[0] = {24'hA00003, 24'hA00002, 24'hA00001, 24'hA00000};
        bb[1] = {24'hB00003, 24'hB00002, 24'hB00001, 24'hB00000};
        bb[2] = {24'hC00003, 24'hC00002, 24'hC00001, 24'hC00000};

        // Reset state, with a frame offered during reset
        rst_n = 1'b0; s_frame_d = vecs[0].frame; s_frame_dv = 1'b1;
        ch_enable = 4'hF; sync_enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", s_frame_rdy, 0);
        chk("rst_dv", vm_signal_dv, 0);
        chk("rst_d", vm_signal_d, 0);
        chk("rst_ch", vm_signal_ch, 0);
        chk("rst_sync", vm_sync, 0);
        s_frame_dv = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", s_frame_rdy, 1);
        chk("rel_dv", vm_signal_dv, 0);

        // Table-driven frame scans
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            chk("vec_rdy_pre", s_frame_rdy, 1);
            s_frame_d = vecs[v].frame; ch_enable = vecs[v].mask; s_frame_dv = 1'b1;
            @(negedge clk);
            s_frame_dv = 1'b0; s_frame_d = ~vecs[v].frame; ch_enable = ~vecs[v].mask;
            for (int k = 0; k < vecs[v].n; k++) begin
                if (k > 0) @(negedge clk);
                chk("vec_dv", vm_signal_dv, 1);
                chk("vec_ch", vm_signal_ch, vecs[v].ch[k]);
                chk("vec_d", vm_signal_d, vecs[v].d[k]);
                chk("vec_rdy_busy", s_frame_rdy, 0);
            end
            if (vecs[v].n > 0) begin
                @(negedge clk);
                chk("vec_hold_ch", vm_signal_ch, vecs[v].ch[vecs[v].n-1]);
                chk("vec_hold_d", vm_signal_d, vecs[v].d[vecs[v].n-1]);
            end
            chk("vec_dv_end", vm_signal_dv, 0);
            chk("vec_rdy_end", s_frame_rdy, 1);
            ch_enable = 4'h0;
        end

        // Dropped frame followed immediately by an accepted one
        @(negedge clk);
        s_frame_d = vecs[0].frame; ch_enable = 4'h0; s_frame_dv = 1'b1;
        @(negedge clk);
        chk("drop_dv", vm_signal_dv, 0);
        chk("drop_rdy", s_frame_rdy, 1);
        s_frame_d = {72'h0, 24'hABCDEF}; ch_enable = 4'h1;
        @(negedge clk);
        s_frame_dv = 1'b0;
        chk("next_dv", vm_signal_dv, 1);
        chk("next_ch", vm_signal_ch, 0);
        chk("next_d", vm_signal_d, 24'hABCDEF);
        chk("next_rdy", s_frame_rdy, 0);
        @(negedge clk);
        chk("next_dv_end", vm_signal_dv, 0);
        chk("next_rdy_end", s_frame_rdy, 1);

        // Sync pacing, drop mid-period, re-enable
        @(negedge clk);
        sync_enable = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            chk("sync_run", vm_sync, (k % 8 == 0) ? 1 : 0);
        end
        sync_enable = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("sync_off", vm_sync, 0);
        end
        sync_enable = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("sync_reen", vm_sync, (k % 8 == 0) ? 1 : 0);
        end
        sync_enable = 1'b0;
        @(negedge clk);

        // Back-to-back frames with dv held high; sync lands on emissions
        @(negedge clk);
        sync_enable = 1'b1; rel = 0;
        repeat (5) begin
            @(negedge clk); rel++;
            chk("b2b_sync_pre", vm_sync, (rel % 8 == 0) ? 1 : 0);
        end
        s_frame_dv = 1'b1; s_frame_d = bb[0]; ch_enable = 4'b0111;
        for (int f = 0; f < 3; f++) begin
            chk("b2b_rdy", s_frame_rdy, 1);
            @(negedge clk); rel++;
            if (f < 2) s_frame_d = bb[f+1];
            else s_frame_dv = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (k > 0) begin
                    @(negedge clk); rel++;
                end
                chk("b2b_dv", vm_signal_dv, 1);
                chk("b2b_ch", vm_signal_ch, k);
                chk("b2b_d", vm_signal_d, bb[f][k*24 +: 24]);
                chk("b2b_sync", vm_sync, (rel % 8 == 0) ? 1 : 0);
            end
            @(negedge clk); rel++;
            chk("b2b_gap_dv", vm_signal_dv, 0);
            chk("b2b_gap_sync", vm_sync, (rel % 8 == 0) ? 1 : 0);
        end
        sync_enable = 1'b0;

        // Reset in the middle of a 4-channel scan
        @(negedge clk);
        chk("mr_rdy_pre", s_frame_rdy, 1);
        s_frame_d = vecs[1].frame; ch_enable = 4'hF; s_frame_dv = 1'b1;
        @(negedge clk);
        s_frame_dv = 1'b0;
        chk("mr_ch0", vm_signal_ch, 0);
        chk("mr_d0", vm_signal_d, 24'h111111);
        @(negedge clk);
        chk("mr_ch1", vm_signal_ch, 1);
        chk("mr_dv1", vm_signal_dv, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_dv", vm_signal_dv, 0);
        chk("mr_d", vm_signal_d, 0);
        chk("mr_ch", vm_signal_ch, 0);
        chk("mr_rdy", s_frame_rdy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rel_rdy", s_frame_rdy, 1);
        repeat (8) begin
            chk("mr_no_stale", vm_signal_dv, 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
